// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory arbiter, round-robin with optional grant locking
// Locking (LOCK0/LOCK1 ownership, MAX_LOCK cap) is compiled in only when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter #(
    parameter int MAX_LOCK = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_wmask_i,
    input  logic        m0_lock_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_wmask_i,
    input  logic        m1_lock_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic [31:0] dmem_A_o,
    output logic [31:0] dmem_WD_o,
    output logic        dmem_WE_o,
    output logic [3:0]  dmem_WMASK_o,
    input  logic [31:0] dmem_RD_i
);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

`ifdef DMEM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic gnt0, gnt1;
    logic owner_active;
    logic lock_g;

    // ptr_q = 0 favours m0, 1 favours m1 when both request
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        owner_active = (state_q == LOCK0 && m0_req_i) || (state_q == LOCK1 && m1_req_i);
        if (!rst_i) begin
            if (state_q == LOCK0 && m0_req_i) begin
                gnt0 = 1'b1;
            end else if (state_q == LOCK1 && m1_req_i) begin
                gnt1 = 1'b1;
            end else if (m0_req_i && m1_req_i) begin
                gnt0 = ~ptr_q;
                gnt1 = ptr_q;
            end else begin
                gnt0 = m0_req_i;
                gnt1 = m1_req_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        lock_g  = gnt0 ? m0_lock_i : m1_lock_i;

        if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end

        // An absent owner releases the lock and falls through to normal arbitration
        if (owner_active) begin
            cnt_d = cnt_q + 4'd1;
            if (!lock_g || cnt_d == MAX_CNT) begin
                state_d = ARB;
                cnt_d   = 4'd0;
            end
        end else if (LOCK_EN && (gnt0 || gnt1) && lock_g) begin
            state_d = gnt0 ? LOCK0 : LOCK1;
            cnt_d   = 4'd1;
        end else begin
            state_d = ARB;
            cnt_d   = 4'd0;
        end

        rvalid0_d = gnt0 && !m0_we_i;
        rvalid1_d = gnt1 && !m1_we_i;
        rdata0_d  = rvalid0_d ? dmem_RD_i : rdata0_q;
        rdata1_d  = rvalid1_d ? dmem_RD_i : rdata1_q;
    end

    always_comb begin
        dmem_A_o     = 32'd0;
        dmem_WD_o    = 32'd0;
        dmem_WE_o    = 1'b0;
        dmem_WMASK_o = 4'd0;
        if (gnt0) begin
            dmem_A_o     = m0_addr_i;
            dmem_WD_o    = m0_wdata_i;
            dmem_WE_o    = m0_we_i;
            dmem_WMASK_o = m0_wmask_i;
        end else if (gnt1) begin
            dmem_A_o     = m1_addr_i;
            dmem_WD_o    = m1_wdata_i;
            dmem_WE_o    = m1_we_i;
            dmem_WMASK_o = m1_wmask_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB;
            ptr_q     <= 1'b0;
            cnt_q     <= 4'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign m0_rvalid_o = rvalid0_q;
    assign m1_rvalid_o = rvalid1_q;
    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wmask;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wmask;
    logic [31:0] dmem_a, dmem_wd, dmem_rd;
    logic        dmem_we;
    logic [3:0]  dmem_wmask;

    logic [31:0] ram [0:15];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_LOCK(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_wmask_i(m0_wmask), .m0_lock_i(m0_lock), .m0_gnt_o(m0_gnt),
        .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_wmask_i(m1_wmask), .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt),
        .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .dmem_A_o(dmem_a), .dmem_WD_o(dmem_wd), .dmem_WE_o(dmem_we),
        .dmem_WMASK_o(dmem_wmask), .dmem_RD_i(dmem_rd)
    );

    assign dmem_rd = ram[dmem_a[5:2]];

    always @(posedge clk) begin
        if (dmem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_wmask[b]) ram[dmem_a[5:2]][8*b +: 8] <= dmem_wd[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wmask, input logic lock);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wmask = wmask; m0_lock = lock;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wmask, input logic lock);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_wmask = wmask; m1_lock = lock;
    endtask

    task automatic idle();
        drive_m0(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        drive_m1(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'h5A5A_0000 + i;
        ram[4] = 32'hDEADBEEF;
        ram[2] = 32'h0;

        // Reset with both requesters active: everything must stay quiet
        rst = 1'b1;
        drive_m0(1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b0);
        drive_m1(1'b1, 1'b1, 32'h44, 32'h1234_5678, 4'hF, 1'b0);
        #1;
        check("rst_gnt0", m0_gnt, 1'b0);
        check("rst_gnt1", m1_gnt, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        check("rst_a", dmem_a, 32'h0);
        check("rst_wd", dmem_wd, 32'h0);
        check("rst_wmask", dmem_wmask, 4'h0);
        tick();
        check("rst_rvalid0", m0_rvalid, 1'b0);
        check("rst_rvalid1", m1_rvalid, 1'b0);
        check("rst_rdata0", m0_rdata, 32'h0);
        check("rst_rdata1", m1_rdata, 32'h0);
        rst = 1'b0;
        idle();

        // Single read from m0
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        #1;
        check("rd_gnt0", m0_gnt, 1'b1);
        check("rd_gnt1", m1_gnt, 1'b0);
        check("rd_a", dmem_a, 32'h10);
        check("rd_we", dmem_we, 1'b0);
        tick();
        idle();
        check("rd_rvalid0", m0_rvalid, 1'b1);
        check("rd_rdata0", m0_rdata, 32'hDEADBEEF);
        check("rd_rvalid1", m1_rvalid, 1'b0);
        tick();
        check("rd_pulse", m0_rvalid, 1'b0);
        check("rd_hold", m0_rdata, 32'hDEADBEEF);

        // Reset returns the pointer to m0 (last grant went to m0)
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Both write for 4 cycles: alternate m0,m1,m0,m1
        drive_m0(1'b1, 1'b1, 32'h20, 32'hA0A0A0A0, 4'hF, 1'b0);
        drive_m1(1'b1, 1'b1, 32'h24, 32'hB1B1B1B1, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_gnt0_%0d", i), m0_gnt, (i % 2 == 0));
            check($sformatf("rr_gnt1_%0d", i), m1_gnt, (i % 2 == 1));
            check($sformatf("rr_we_%0d", i), dmem_we, 1'b1);
            check($sformatf("rr_a_%0d", i), dmem_a, (i % 2 == 0) ? 32'h20 : 32'h24);
            tick();
            check($sformatf("rr_norv0_%0d", i), m0_rvalid, 1'b0);
            check($sformatf("rr_norv1_%0d", i), m1_rvalid, 1'b0);
        end
        idle();
        check("rr_ram8", ram[8], 32'hA0A0A0A0);
        check("rr_ram9", ram[9], 32'hB1B1B1B1);

        // Masked byte write from m1
        drive_m1(1'b1, 1'b1, 32'h8, 32'h11223344, 4'b0010, 1'b0);
        #1;
        check("mw_gnt1", m1_gnt, 1'b1);
        check("mw_wmask", dmem_wmask, 4'b0010);
        check("mw_wd", dmem_wd, 32'h11223344);
        tick();
        idle();
        check("mw_ram2", ram[2], 32'h00003300);

        // Lone m1 request wins although the pointer favours m0
        drive_m1(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
        #1;
        check("single_gnt1", m1_gnt, 1'b1);
        check("single_gnt0", m0_gnt, 1'b0);
        tick();
        idle();
        check("single_rvalid1", m1_rvalid, 1'b1);
        check("single_rdata1", m1_rdata, 32'h00003300);
        check("single_rvalid0", m0_rvalid, 1'b0);
        check("single_rdata0", m0_rdata, 32'h0);

        // No request: bus outputs stay zero even with live inputs
        drive_m0(1'b0, 1'b1, 32'h44, 32'h99887766, 4'hF, 1'b0);
        #1;
        check("idle_a", dmem_a, 32'h0);
        check("idle_wd", dmem_wd, 32'h0);
        check("idle_we", dmem_we, 1'b0);
        check("idle_wmask", dmem_wmask, 4'h0);
        tick();
        idle();

`ifndef DMEM_ARB_LOCK_EN
        // Lock requests ignored: still plain round-robin
        drive_m0(1'b1, 1'b1, 32'h30, 32'h1, 4'hF, 1'b1);
        drive_m1(1'b1, 1'b1, 32'h34, 32'h2, 4'hF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("nolock_gnt0_%0d", i), m0_gnt, (i % 2 == 0));
            check($sformatf("nolock_gnt1_%0d", i), m1_gnt, (i % 2 == 1));
            tick();
        end
        idle();
`else
        // m0 locks with both requesting: m0 x4, then m1, then m0
        drive_m0(1'b1, 1'b1, 32'h30, 32'h1, 4'hF, 1'b1);
        drive_m1(1'b1, 1'b1, 32'h34, 32'h2, 4'hF, 1'b0);
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("lock_gnt0_%0d", i), m0_gnt, (i != 4));
            check($sformatf("lock_gnt1_%0d", i), m1_gnt, (i == 4));
            tick();
        end

        // Reset while in LOCK0 with a read pending
        rst = 1'b1;
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        #1;
        check("lrst_gnt0", m0_gnt, 1'b0);
        check("lrst_gnt1", m1_gnt, 1'b0);
        tick();
        rst = 1'b0;
        check("lrst_rvalid0", m0_rvalid, 1'b0);
        drive_m0(1'b1, 1'b1, 32'h30, 32'h3, 4'hF, 1'b0);
        drive_m1(1'b1, 1'b1, 32'h34, 32'h4, 4'hF, 1'b0);
        #1;
        check("lrst_next_gnt0", m0_gnt, 1'b1);
        check("lrst_next_gnt1", m1_gnt, 1'b0);
        tick();

        // m1 locks, then drops its request: m0 granted that same cycle
        drive_m1(1'b1, 1'b1, 32'h34, 32'h5, 4'hF, 1'b1);
        #1;
        check("l1_gnt1", m1_gnt, 1'b1);
        tick();
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        check("l1_drop_gnt0", m0_gnt, 1'b1);
        check("l1_drop_gnt1", m1_gnt, 1'b0);
        tick();
        idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
